// File: rtl/alu_pkg.sv
// Shared types and widths for the alu datapath and its command issuer front end.
package alu_pkg;

    localparam int OPC_W = 3;
    localparam int OP_W  = 4;
    localparam int RES_W = 8;
    localparam int TAG_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } issuer_state_t;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [OP_W-1:0]  op1;
        logic [OP_W-1:0]  op2;
        logic [TAG_W-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO of alu_cmd_t with a registered full flag and
// a combinational read port showing the head entry.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  alu_cmd_t push_data,
    input  logic     pop,
    output alu_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    alu_cmd_t        mem_q [DEPTH];
    alu_cmd_t        mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_q, full_d;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (cnt_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Pointers wrap for free because DEPTH is a power of two.
        full_d = (cnt_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues buffered tagged commands to the ALU one at a time, waits the fixed
// ALU latency, and returns each result with its tag over a valid/ready port.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPC_W-1:0] cmd_opcode,
    input  logic [OP_W-1:0]  cmd_op1,
    input  logic [OP_W-1:0]  cmd_op2,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [OPC_W-1:0] alu_opcode,
    output logic [OP_W-1:0]  alu_op1,
    output logic [OP_W-1:0]  alu_op2,
    input  logic [RES_W-1:0] alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_res,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [OPC_W-1:0] rsp_opcode,
    output logic             busy,
    output issuer_state_t    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable while valid && !ready.

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    issuer_state_t    state_q, state_d;
    alu_cmd_t         alu_cmd_q, alu_cmd_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic [RES_W-1:0] rsp_res_q, rsp_res_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [OPC_W-1:0] rsp_opcode_q, rsp_opcode_d;

    alu_cmd_t         fifo_din;
    alu_cmd_t         fifo_dout;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign cmd_ready = !fifo_full && !rst;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_din  = '{opcode: cmd_opcode, op1: cmd_op1, op2: cmd_op2, tag: cmd_tag};

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        alu_cmd_d    = alu_cmd_q;
        lat_cnt_d    = lat_cnt_q;
        rsp_res_d    = rsp_res_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_opcode_d = rsp_opcode_q;
        fifo_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    alu_cmd_d = fifo_dout;
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_res_d    = alu_res;
                    rsp_tag_d    = alu_cmd_q.tag;
                    rsp_opcode_d = alu_cmd_q.opcode;
                    state_d      = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Chain straight into the next command to avoid a dead IDLE cycle.
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        alu_cmd_d = fifo_dout;
                        lat_cnt_d = LAT_INIT;
                        state_d   = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_cmd_q    <= '0;
            lat_cnt_q    <= '0;
            rsp_res_q    <= '0;
            rsp_tag_q    <= '0;
            rsp_opcode_q <= '0;
        end else begin
            state_q      <= state_d;
            alu_cmd_q    <= alu_cmd_d;
            lat_cnt_q    <= lat_cnt_d;
            rsp_res_q    <= rsp_res_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_opcode_q <= rsp_opcode_d;
        end
    end

    assign alu_opcode = alu_cmd_q.opcode;
    assign alu_op1    = alu_cmd_q.op1;
    assign alu_op2    = alu_cmd_q.op2;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_res    = rsp_res_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_opcode = rsp_opcode_q;
    assign busy       = !rst && (!fifo_empty || (state_q != IDLE));
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed self-checking bench for alu_cmd_issuer with an expected-response
// queue drained by an independent response monitor.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int W = TAG_W + OPC_W + RES_W;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPC_W-1:0] cmd_opcode;
    logic [OP_W-1:0]  cmd_op1;
    logic [OP_W-1:0]  cmd_op2;
    logic [TAG_W-1:0] cmd_tag;
    logic [OPC_W-1:0] alu_opcode;
    logic [OP_W-1:0]  alu_op1;
    logic [OP_W-1:0]  alu_op2;
    logic [RES_W-1:0] alu_res;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_res;
    logic [TAG_W-1:0] rsp_tag;
    logic [OPC_W-1:0] rsp_opcode;
    logic             busy;
    issuer_state_t    dbg_state;

    logic [W-1:0] exp_q[$];
    int           hs_cyc[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;

    localparam logic [3:0] WA [10] = '{4'hF, 4'h1, 4'h2, 4'h9, 4'hF, 4'h0, 4'h8, 4'hC, 4'hA, 4'hE};
    localparam logic [3:0] WB [10] = '{4'hF, 4'h1, 4'h3, 4'h9, 4'h1, 4'h0, 4'h7, 4'h5, 4'hA, 4'hF};
    localparam logic [7:0] WR [10] = '{8'h1E, 8'h02, 8'h05, 8'h12, 8'h10, 8'h00, 8'h0F, 8'h11, 8'h14, 8'h1D};

    alu_cmd_issuer #(
        .ALU_LAT (1),
        .DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_op1    (cmd_op1),
        .cmd_op2    (cmd_op2),
        .cmd_tag    (cmd_tag),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_res    (alu_res),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_tag    (rsp_tag),
        .rsp_opcode (rsp_opcode),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ALU model with one cycle of latency behind the registered alu_* drive.
    assign alu_res = (alu_opcode == 3'b001) ? (RES_W'(alu_op1) + RES_W'(alu_op2))
                                            : {alu_op1, alu_op2};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] tag, input logic [7:0] exp_res);
        logic r;
        bit   ok;
        cmd_opcode = opc;
        cmd_op1    = a;
        cmd_op2    = b;
        cmd_tag    = tag;
        cmd_valid  = 1'b1;
        ok         = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
        end
        cmd_valid = 1'b0;
        if (ok) begin
            exp_q.push_back({tag, opc, exp_res});
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept tag=%0d", tag);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic single_cmd(input logic [3:0] a, input logic [3:0] b,
                              input logic [1:0] tag, input logic [7:0] res);
        send(3'b001, a, b, tag, res);
        check("busy_after_accept", busy, 1);
        @(posedge clk);
        #1;
        check("alu_opcode_load", alu_opcode, 3'b001);
        check("alu_op1_load", alu_op1, a);
        check("alu_op2_load", alu_op2, b);
        check("rsp_valid_early", rsp_valid, 0);
        @(posedge clk);
        #1;
        check("rsp_valid_e2", rsp_valid, 1);
        check("rsp_res_e2", rsp_res, res);
        check("rsp_tag_e2", rsp_tag, tag);
        wait_drain(20);
        check("busy_idle", busy, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got tag=%0d res=%0h want none", rsp_tag, rsp_res);
            end else begin
                e = exp_q.pop_front();
                check("rsp_fields", {rsp_tag, rsp_opcode, rsp_res}, e);
            end
            hs_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_op1    = '0;
        cmd_op2    = '0;
        cmd_tag    = '0;
        rsp_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        #1;
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_busy", busy, 0);
        check("rel_alu", {alu_opcode, alu_op1, alu_op2}, 0);
        check("rel_rsp", {rsp_valid, rsp_res, rsp_tag, rsp_opcode}, 0);
        check("rel_state", 32'(dbg_state), 32'(IDLE));

        // single command
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        single_cmd(4'h3, 4'h5, 2'd2, 8'h08);

        // fill the FIFO against a stalled response port
        rsp_ready = 1'b0;
        send(3'b001, 4'h1, 4'h2, 2'd0, 8'h03);
        send(3'b001, 4'h4, 4'h4, 2'd1, 8'h08);
        send(3'b010, 4'h6, 4'h9, 2'd2, 8'h69);
        send(3'b001, 4'h7, 4'h8, 2'd3, 8'h0F);
        send(3'b111, 4'hA, 4'hB, 2'd0, 8'hAB);
        check("full_cmd_ready", cmd_ready, 0);
        check("full_rsp_valid", rsp_valid, 1);
        check("full_rsp_res", rsp_res, 8'h03);
        repeat (3) @(posedge clk);
        #1;
        check("frozen_rsp", {rsp_valid, rsp_tag, rsp_opcode, rsp_res}, {1'b1, 2'd0, 3'b001, 8'h03});
        check("frozen_cmd_ready", cmd_ready, 0);
        check("frozen_state", 32'(dbg_state), 32'(RESP));

        hs_cyc.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_cmd_ready", cmd_ready, 1);
        wait_drain(40);
        check("drain_count", hs_cyc.size(), 5);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("rsp_spacing", hs_cyc[i] - hs_cyc[i-1], 2);

        // ten commands through a depth-4 FIFO
        for (int i = 0; i < 10; i++)
            send(3'b001, WA[i], WB[i], 2'(i), WR[i]);
        wait_drain(60);

        // reset while in WAIT with two commands queued
        rsp_ready = 1'b0;
        send(3'b001, 4'h1, 4'h1, 2'd1, 8'h02);
        send(3'b001, 4'h2, 4'h2, 2'd2, 8'h04);
        send(3'b001, 4'h3, 4'h3, 2'd3, 8'h06);
        send(3'b001, 4'h4, 4'h4, 2'd0, 8'h08);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("pre_rst_state", 32'(dbg_state), 32'(WAIT));
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_alu", {alu_opcode, alu_op1, alu_op2}, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        seen      = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        check("no_rsp_after_rst", seen, 0);
        single_cmd(4'h6, 4'h7, 2'd1, 8'h0D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
